fetch_unit: RTL and testbench

Instruction fetch unit that owns the architectural PC and consumes the `next_pc` value chosen by the sequencer. It fetches one instruction at a time over a valid/ready instruction-memory port, presents it to decode with a valid/ready handshake, and supplies the fall-through address PC+4 back to the sequencer as its `notbranch` input. The core is multicycle with one instruction in flight; the PC advances only when execute signals that `next_pc` is final.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit sequencer, imem and decode handshake bundle
interface fetch_unit_if;
    logic [31:0] next_pc;
    logic        pc_update;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        misalign_err;

    modport master (
        input  next_pc, pc_update, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4, misalign_err
    );

    modport slave (
        output next_pc, pc_update, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4, misalign_err
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-issue instruction fetch unit owning the architectural PC
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_EXEC,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        misalign_q, misalign_d;
    logic        req_valid_q, req_valid_d;
    logic        inst_valid_q, inst_valid_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        misalign_d = misalign_q;

        case (state_q)
            // req_valid_q is low for the reset cycle, so no request can be accepted then
            S_REQ: begin
                if (req_valid_q && bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_resp_valid) begin
                    inst_d  = bus.imem_resp_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.inst_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.pc_update) begin
                    if (bus.next_pc[1:0] == 2'b00) begin
                        pc_d    = bus.next_pc;
                        state_d = S_REQ;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = S_ERR;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        // Valids are registered from the next state so outputs never see inputs combinationally
        req_valid_d  = (state_d == S_REQ);
        inst_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            misalign_q   <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            misalign_q   <= misalign_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = pc_q;
    assign bus.inst_pc_plus4  = pc_q + 32'd4;
    assign bus.misalign_err   = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_exec(input logic [31:0] data);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.inst_ready      = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic retire(input logic [31:0] npc);
        bus.next_pc   = npc;
        bus.pc_update = 1'b1;
        tick();
        bus.pc_update = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.next_pc = 32'h0; bus.pc_update = 1'b0; bus.imem_req_ready = 1'b0;
        bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'h0; bus.inst_ready = 1'b0;
        tick();
        tick();
        vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b required 0", bus.imem_req_valid); end
        vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h required 00000000", bus.imem_addr); end
        vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_inst_valid: got %b required 0", bus.inst_valid); end
        vectors++; if (bus.inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h required 00000000", bus.inst); end
        vectors++; if (bus.inst_pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL rst_pc_plus4: got %h required 00000004", bus.inst_pc_plus4); end
        vectors++; if (bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL rst_misalign: got %b required 0", bus.misalign_err); end
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL post_rst_req_valid: got %b required 1", bus.imem_req_valid); end
    endtask

    task automatic test_zero_wait();
        int t0;
        t0 = cyc;
        vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL zw_addr0: got %h required 00000000", bus.imem_addr); end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL zw_wait_req_valid: got %b required 0", bus.imem_req_valid); end
        bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_0013;
        tick();
        bus.imem_resp_valid = 1'b0;
        vectors++; if (bus.inst_valid !== 1'b1) begin miscompares++; $display("FAIL zw_inst_valid: got %b required 1", bus.inst_valid); end
        vectors++; if (bus.inst !== 32'h0000_0013) begin miscompares++; $display("FAIL zw_inst: got %h required 00000013", bus.inst); end
        vectors++; if (bus.inst_pc !== 32'h0) begin miscompares++; $display("FAIL zw_inst_pc: got %h required 00000000", bus.inst_pc); end
        vectors++; if (bus.inst_pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL zw_pc_plus4: got %h required 00000004", bus.inst_pc_plus4); end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL zw_exec_inst_valid: got %b required 0", bus.inst_valid); end
        retire(32'h0000_0004);
        vectors++; if (bus.imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL zw_req2_valid: got %b required 1", bus.imem_req_valid); end
        vectors++; if (bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL zw_addr1: got %h required 00000004", bus.imem_addr); end
        vectors++; if (cyc - t0 != 4) begin miscompares++; $display("FAIL zw_loop_cycles: got %0d required 4", cyc - t0); end
    endtask

    task automatic test_req_stall();
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL stall_req_valid[%0d]: got %b required 1", i, bus.imem_req_valid); end
            vectors++; if (bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL stall_addr[%0d]: got %h required 00000004", i, bus.imem_addr); end
            tick();
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL stall_accepted: got %b required 0", bus.imem_req_valid); end
        bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h0000_00AA;
        tick();
        bus.imem_resp_valid = 1'b0;
    endtask

    task automatic test_hold_stall();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.inst_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b required 1", i, bus.inst_valid); end
            vectors++; if (bus.inst !== 32'h0000_00AA) begin miscompares++; $display("FAIL hold_inst[%0d]: got %h required 000000aa", i, bus.inst); end
            vectors++; if (bus.inst_pc !== 32'h4) begin miscompares++; $display("FAIL hold_inst_pc[%0d]: got %h required 00000004", i, bus.inst_pc); end
            if (i == 2) begin bus.next_pc = 32'h100; bus.pc_update = 1'b1; end
            tick();
            bus.pc_update = 1'b0;
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        vectors++; if (bus.inst_pc !== 32'h4) begin miscompares++; $display("FAIL hold_pulse_ignored: got %h required 00000004", bus.inst_pc); end
        vectors++; if (bus.inst !== 32'h0000_00AA) begin miscompares++; $display("FAIL exec_inst: got %h required 000000aa", bus.inst); end
        tick();
        vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL exec_idle_req: got %b required 0", bus.imem_req_valid); end
        retire(32'h0000_0100);
        vectors++; if (bus.imem_addr !== 32'h100) begin miscompares++; $display("FAIL exec_load_pc: got %h required 00000100", bus.imem_addr); end
    endtask

    task automatic test_branch_wrap();
        run_to_exec(32'h1111_1111);
        retire(32'h8000_0040);
        vectors++; if (bus.imem_addr !== 32'h8000_0040) begin miscompares++; $display("FAIL branch_addr: got %h required 80000040", bus.imem_addr); end
        run_to_exec(32'h2222_2222);
        retire(32'hFFFF_FFFC);
        vectors++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got %h required fffffffc", bus.imem_addr); end
        vectors++; if (bus.inst_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_plus4: got %h required 00000000", bus.inst_pc_plus4); end
        run_to_exec(32'h3333_3333);
        vectors++; if (bus.inst !== 32'h3333_3333) begin miscompares++; $display("FAIL wrap_inst: got %h required 33333333", bus.inst); end
    endtask

    task automatic test_misalign();
        retire(32'h0000_0102);
        vectors++; if (bus.misalign_err !== 1'b1) begin miscompares++; $display("FAIL mis_err: got %b required 1", bus.misalign_err); end
        vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mis_req_valid: got %b required 0", bus.imem_req_valid); end
        vectors++; if (bus.inst_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL mis_pc: got %h required fffffffc", bus.inst_pc); end
        bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b1; bus.inst_ready = 1'b1;
        bus.next_pc = 32'h200; bus.pc_update = 1'b1;
        tick();
        tick();
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.inst_ready = 1'b0; bus.pc_update = 1'b0;
        vectors++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL err_valids: got %b%b required 00", bus.imem_req_valid, bus.inst_valid); end
        vectors++; if (bus.misalign_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b required 1", bus.misalign_err); end
        vectors++; if (bus.inst_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL err_pc: got %h required fffffffc", bus.inst_pc); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL recover_req_valid: got %b required 1", bus.imem_req_valid); end
        vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL recover_addr: got %h required 00000000", bus.imem_addr); end
        vectors++; if (bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL recover_err: got %b required 0", bus.misalign_err); end
    endtask

    task automatic test_reset_mid();
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        vectors++; if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mid_in_wait: got %b required 0", bus.imem_req_valid); end
        rst_n = 1'b0;
        bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hDEAD_BEEF;
        tick();
        bus.imem_resp_valid = 1'b0;
        rst_n = 1'b1;
        vectors++; if (bus.inst !== 32'h0) begin miscompares++; $display("FAIL mid_inst: got %h required 00000000", bus.inst); end
        tick();
        vectors++; if (bus.imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL mid_req_valid: got %b required 1", bus.imem_req_valid); end
        vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_addr: got %h required 00000000", bus.imem_addr); end
        vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL mid_inst_valid: got %b required 0", bus.inst_valid); end
        vectors++; if (bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL mid_err: got %b required 0", bus.misalign_err); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_req_stall();
        test_hold_stall();
        test_branch_wrap();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
